// File: rtl/adder_sum_serializer.sv
// Captures one wide adder sum and streams it out LSB-first as CHUNK_WIDTH chunks
// over valid/ready, accepting the next word on the edge that retires the last chunk.
module adder_sum_serializer #(
    parameter int unsigned SUM_WIDTH   = 128,
    parameter int unsigned CHUNK_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SUM_WIDTH-1:0]   sum_in,
    input  logic                   sum_valid,
    output logic                   sum_ready,
    output logic [CHUNK_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned NUM_CHUNKS  = (SUM_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int unsigned CNT_WIDTH   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned SHIFT_WIDTH = NUM_CHUNKS * CHUNK_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_CHUNKS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   capture;
    logic                   accept;
    logic                   last;

    assign capture = sum_valid && sum_ready;
    assign accept  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sum_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (accept && last) begin
                    state_next = sum_valid ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs derive from registers only; sum_ready also looks at out_ready so a
    // new word can land on the same edge the last chunk leaves.
    always_comb begin
        out_valid = (state == SHIFT);
        last      = (state == SHIFT) && (cnt_q == LAST_IDX);
        out_last  = last;
        busy      = (state == SHIFT);
        out_data  = shift_q[CHUNK_WIDTH-1:0];
        sum_ready = (state == IDLE) || (last && out_ready);
    end

    // Shift register and chunk counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (capture) begin
            shift_q <= SHIFT_WIDTH'(sum_in);
            cnt_q   <= '0;
        end else if (accept && !last) begin
            shift_q <= shift_q >> CHUNK_WIDTH;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_adder_sum_serializer.sv
// Self-checking bench: three serializer configurations (128/16, 127/16, 16/16)
// with a chunk scoreboard filled at word capture and drained at chunk accept.
module tb_adder_sum_serializer;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } chunk_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] sum_in = '0;
    logic         sum_valid = 1'b0;
    logic         out_ready = 1'b0;
    int           sel = 0;

    logic [2:0]   sv;
    logic [2:0]   s_ready, s_valid, s_last, s_busy;
    logic [15:0]  s_data [3];

    logic         o_sum_ready, o_valid, o_last, o_busy;
    logic [15:0]  o_data;

    chunk_t       sb[$];
    chunk_t       e;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    assign sv[0] = sum_valid && (sel == 0);
    assign sv[1] = sum_valid && (sel == 1);
    assign sv[2] = sum_valid && (sel == 2);

    adder_sum_serializer #(.SUM_WIDTH(128), .CHUNK_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sv[0]), .sum_ready(s_ready[0]),
        .out_data(s_data[0]), .out_valid(s_valid[0]), .out_ready(out_ready),
        .out_last(s_last[0]), .busy(s_busy[0]));

    adder_sum_serializer #(.SUM_WIDTH(127), .CHUNK_WIDTH(16)) u_dut127 (
        .clk(clk), .rst(rst), .sum_in(sum_in[126:0]), .sum_valid(sv[1]), .sum_ready(s_ready[1]),
        .out_data(s_data[1]), .out_valid(s_valid[1]), .out_ready(out_ready),
        .out_last(s_last[1]), .busy(s_busy[1]));

    adder_sum_serializer #(.SUM_WIDTH(16), .CHUNK_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .sum_in(sum_in[15:0]), .sum_valid(sv[2]), .sum_ready(s_ready[2]),
        .out_data(s_data[2]), .out_valid(s_valid[2]), .out_ready(out_ready),
        .out_last(s_last[2]), .busy(s_busy[2]));

    always_comb begin
        o_sum_ready = s_ready[0];
        o_valid     = s_valid[0];
        o_last      = s_last[0];
        o_busy      = s_busy[0];
        o_data      = s_data[0];
        case (sel)
            1: begin
                o_sum_ready = s_ready[1]; o_valid = s_valid[1]; o_last = s_last[1];
                o_busy = s_busy[1]; o_data = s_data[1];
            end
            2: begin
                o_sum_ready = s_ready[2]; o_valid = s_valid[2]; o_last = s_last[2];
                o_busy = s_busy[2]; o_data = s_data[2];
            end
            default: ;
        endcase
    end

    // Drive one cycle of inputs at the falling edge and let combinational outputs settle.
    task automatic drive(input logic v, input logic [127:0] w, input logic r);
        @(negedge clk);
        sum_valid = v;
        sum_in    = w;
        out_ready = r;
        #1;
    endtask

    // Queue the chunks a word of width sw should produce, LSB first, zero above sw.
    task automatic push_word(input logic [127:0] w, input int sw);
        logic [127:0] m;
        chunk_t       c;
        int           n;
        m = w;
        for (int b = sw; b < 128; b++) m[b] = 1'b0;
        n = (sw + 15) / 16;
        for (int i = 0; i < n; i++) begin
            c.data = m[i*16 +: 16];
            c.last = (i == n - 1);
            sb.push_back(c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            n_checks++;
            if ({o_valid, o_last, o_busy, o_sum_ready, o_data} !== {4'b0001, 16'h0000}) begin
                n_fail++;
                $display("FAIL reset[%0d]: valid/last/busy/ready/data=%b%b%b%b/%h required 0001/0000",
                         k, o_valid, o_last, o_busy, o_sum_ready, o_data);
            end
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        logic [127:0] w;
        w = 128'h0123456789ABCDEF_FEDCBA9876543210;
        sel = 0;
        drive(1'b1, w, 1'b1);
        n_checks++;
        if (o_sum_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single idle sum_ready: got %b required 1", o_sum_ready);
        end
        if (sum_valid && o_sum_ready) push_word(w, 128);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b1);
            n_checks++;
            if (o_valid !== 1'b1 || o_sum_ready !== (k == 7)) begin
                n_fail++;
                $display("FAIL single cycle %0d: valid=%b sum_ready=%b required 1/%b",
                         k, o_valid, o_sum_ready, (k == 7));
            end
            if (o_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL single chunk: got %h with nothing expected", o_data);
                end else begin
                    e = sb.pop_front();
                    if ({o_data, o_last} !== {e.data, e.last}) begin
                        n_fail++;
                        $display("FAIL single chunk %0d: got %h last=%b required %h last=%b",
                                 k, o_data, o_last, e.data, e.last);
                    end
                end
            end
        end
        drive(1'b0, '0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL single drain: valid=%b pending=%0d required 0/0", o_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pend[$];
        logic [127:0] w;
        logic         v;
        int           cnt, first_c, last_c;
        pend = '{128'h0123456789ABCDEF_FEDCBA9876543210, 128'hA5A55A5A_13579BDF_2468ACE0_0F1E2D3C};
        cnt = 0; first_c = -1; last_c = -1;
        sel = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            v = (pend.size() != 0);
            w = v ? pend[0] : '0;
            drive(v, w, 1'b1);
            if (o_valid) begin
                cnt++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b chunk: got %h with nothing expected", o_data);
                end else begin
                    e = sb.pop_front();
                    if ({o_data, o_last} !== {e.data, e.last}) begin
                        n_fail++;
                        $display("FAIL b2b chunk %0d: got %h last=%b required %h last=%b",
                                 cnt - 1, o_data, o_last, e.data, e.last);
                    end
                end
            end
            if (v && o_sum_ready) begin
                if (pend.size() == 1) begin
                    n_checks++;
                    if (o_valid !== 1'b1 || o_last !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b second capture: valid=%b last=%b required 1/1", o_valid, o_last);
                    end
                end
                push_word(w, 128);
                void'(pend.pop_front());
            end
        end
        n_checks++;
        if (cnt != 16 || (last_c - first_c + 1) != 16 || pend.size() != 0) begin
            n_fail++;
            $display("FAIL b2b stream: chunks=%0d span=%0d unsent=%0d required 16/16/0",
                     cnt, last_c - first_c + 1, pend.size());
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] w;
        logic         r;
        int           accepted, stall;
        w = 128'h0123456789ABCDEF_FEDCBA9876543210;
        accepted = 0; stall = 0;
        sel = 0;
        drive(1'b1, w, 1'b1);
        if (sum_valid && o_sum_ready) push_word(w, 128);
        for (int cyc = 0; cyc < 30 && sb.size() != 0; cyc++) begin
            r = !(accepted == 2 && stall < 3);
            drive(1'b0, '0, r);
            if (!r) begin
                stall++;
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== 16'hBA98 || o_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall %0d: valid=%b data=%h last=%b required 1/ba98/0",
                             stall, o_valid, o_data, o_last);
                end
            end else if (o_valid) begin
                n_checks++;
                e = sb.pop_front();
                accepted++;
                if ({o_data, o_last} !== {e.data, e.last}) begin
                    n_fail++;
                    $display("FAIL stall chunk %0d: got %h last=%b required %h last=%b",
                             accepted - 1, o_data, o_last, e.data, e.last);
                end
            end
        end
        n_checks++;
        if (accepted != 8 || stall != 3) begin
            n_fail++;
            $display("FAIL stall totals: chunks=%0d stalls=%0d required 8/3", accepted, stall);
        end
    endtask

    task automatic test_width127();
        logic [127:0] w;
        logic [15:0]  last_data;
        int           cnt;
        w = '1;
        cnt = 0; last_data = '0;
        sel = 1;
        drive(1'b1, w, 1'b1);
        if (sum_valid && o_sum_ready) push_word(w, 127);
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) begin
            drive(1'b0, '0, 1'b1);
            if (o_valid) begin
                n_checks++;
                e = sb.pop_front();
                cnt++;
                last_data = o_data;
                if ({o_data, o_last} !== {e.data, e.last}) begin
                    n_fail++;
                    $display("FAIL w127 chunk %0d: got %h last=%b required %h last=%b",
                             cnt - 1, o_data, o_last, e.data, e.last);
                end
            end
        end
        n_checks++;
        if (cnt != 8 || last_data !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL w127 totals: chunks=%0d final=%h required 8/7fff", cnt, last_data);
        end
        drive(1'b0, '0, 1'b1);
        sel = 0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] w;
        int           cnt;
        sel = 0;
        w = 128'h0123456789ABCDEF_FEDCBA9876543210;
        drive(1'b1, w, 1'b1);
        if (sum_valid && o_sum_ready) push_word(w, 128);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1);
            n_checks++;
            e = sb.pop_front();
            if ({o_valid, o_data} !== {1'b1, e.data}) begin
                n_fail++;
                $display("FAIL midrst pre chunk %0d: valid=%b data=%h required 1/%h", k, o_valid, o_data, e.data);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_valid, o_sum_ready, o_busy, o_last} !== 4'b0100) begin
            n_fail++;
            $display("FAIL midrst async: valid/ready/busy/last=%b%b%b%b required 0100",
                     o_valid, o_sum_ready, o_busy, o_last);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        w = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
        cnt = 0;
        drive(1'b1, w, 1'b1);
        if (sum_valid && o_sum_ready) push_word(w, 128);
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) begin
            drive(1'b0, '0, 1'b1);
            if (o_valid) begin
                n_checks++;
                e = sb.pop_front();
                cnt++;
                if ({o_data, o_last} !== {e.data, e.last}) begin
                    n_fail++;
                    $display("FAIL midrst post chunk %0d: got %h last=%b required %h last=%b",
                             cnt - 1, o_data, o_last, e.data, e.last);
                end
            end
        end
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL midrst post totals: chunks=%0d required 8", cnt);
        end
    endtask

    task automatic test_num_chunks1();
        logic         v;
        logic [127:0] w;
        sel = 2;
        drive(1'b0, '0, 1'b1);
        for (int cyc = 0; cyc < 5; cyc++) begin
            v = (cyc < 3);
            w = 128'(cyc + 1);
            drive(v, w, 1'b1);
            if (cyc >= 1 && cyc <= 3) begin
                n_checks++;
                if (o_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL nc1 cycle %0d: valid=%b required 1", cyc, o_valid);
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nc1 drain: valid=%b required 0", o_valid);
                end
            end
            if (o_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL nc1 chunk: got %h with nothing expected", o_data);
                end else begin
                    e = sb.pop_front();
                    if ({o_data, o_last} !== {e.data, e.last}) begin
                        n_fail++;
                        $display("FAIL nc1 chunk: got %h last=%b required %h last=%b",
                                 o_data, o_last, e.data, e.last);
                    end
                end
            end
            if (v && o_sum_ready) push_word(w, 16);
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        drive(1'b0, '0, 1'b1);
        test_backpressure();
        drive(1'b0, '0, 1'b1);
        test_width127();
        test_reset_mid();
        drive(1'b0, '0, 1'b1);
        test_num_chunks1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
